fp_add_scheduler: RTL

- Shares one fixed-latency single-precision FP adder core (alignment, add, normalize, round) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle to the adder.
- Tracks the requester ID of each in-flight operation through a tag pipeline matched to adder latency, and returns each result tagged to its requester.
- Provides a drain control so software/test logic can quiesce the adder before reconfiguration or rounding-mode change.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_add_scheduler_rr_arbiter.sv | 33 +++
 rtl/fp_add_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision types and scheduler state encoding for the FP adder
// sharing logic.
package fp_pkg;

  localparam int FP_WIDTH = 32;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] mantissa;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } schedState_t;

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr (wrapping) and
// grants the first asserted request. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grantIdx
);

  logic [ID_W-1:0] idx;

  // Walk the search order backwards so the earliest candidate is written last.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    idx      = '0;
    if (enable) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = ID_W'((int'(ptr) + k) % NUM_REQ);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grantIdx   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency FP adder among NUM_REQ requesters: round-robin issue,
// a requester-tag pipeline matched to the adder latency, and a drain control.
//
// state | meaning
// IDLE  | nothing requested or in flight; arbitration armed
// RUN   | arbitrating and issuing; results returning
// DRAIN | issue blocked; waiting for in-flight results and drain release
module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 3,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   req_opA,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   req_opB,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               add_valid,
  output logic [FP_WIDTH-1:0]                add_opA,
  output logic [FP_WIDTH-1:0]                add_opB,
  input  logic [FP_WIDTH-1:0]                add_result,
  output logic                               rsp_valid,
  output logic [ID_W-1:0]                    rsp_id,
  output logic [FP_WIDTH-1:0]                rsp_data,
  input  logic                               drain,
  output logic                               idle
);

  schedState_t               state;
  logic [ID_W-1:0]           rrPtr;
  logic [ID_W-1:0]           grantIdx;
  logic [ID_W-1:0]           issueId;
  logic                      handshake;
  logic                      arbEnable;
  logic                      anyValid;
  logic                      pipeEmpty;
  logic [ADD_LAT-1:0]        tagValid;
  logic [ADD_LAT-1:0][ID_W-1:0] tagId;
  fp32_t                     selA;
  fp32_t                     selB;

  // Reset gates the grant so req_ready is 0 for the whole reset window.
  assign arbEnable = !reset && !drain && (state != DRAIN);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .req     (req_valid),
    .ptr     (rrPtr),
    .enable  (arbEnable),
    .grant   (req_ready),
    .grantIdx(grantIdx)
  );

  assign handshake = |req_ready;
  assign anyValid  = |req_valid;
  assign selA      = req_opA[grantIdx];
  assign selB      = req_opB[grantIdx];
  // add_valid is the first tag stage; tagValid[k] lines up with the adder k+1 cycles later.
  assign pipeEmpty = !add_valid && !(|tagValid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rrPtr     <= '0;
      add_valid <= 1'b0;
      add_opA   <= '0;
      add_opB   <= '0;
      issueId   <= '0;
      tagValid  <= '0;
      tagId     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      idle      <= 1'b1;
    end else begin
      add_valid <= handshake;
      if (handshake) begin
        add_opA <= selA;
        add_opB <= selB;
        issueId <= grantIdx;
        rrPtr   <= (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
      end

      tagValid[0] <= add_valid;
      tagId[0]    <= issueId;
      for (int k = 1; k < ADD_LAT; k++) begin
        tagValid[k] <= tagValid[k-1];
        tagId[k]    <= tagId[k-1];
      end

      rsp_valid <= tagValid[ADD_LAT-1];
      if (tagValid[ADD_LAT-1]) begin
        rsp_id   <= tagId[ADD_LAT-1];
        rsp_data <= add_result;
      end

      idle <= ((state == IDLE) && !handshake) ||
              ((state == RUN) && !anyValid && pipeEmpty) ||
              ((state == DRAIN) && pipeEmpty);

      case (state)
        IDLE:    if (anyValid && !drain) state <= RUN;
        RUN:     if (drain) state <= DRAIN;
                 else if (!anyValid && pipeEmpty) state <= IDLE;
        DRAIN:   if (!drain && pipeEmpty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
